// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner: sync, debounce and one-shot for plus/clear buttons; define BTN_AUTOREPEAT_EN for plus auto-repeat
module button_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES = 32,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES > REPEAT_CYCLES ? DEBOUNCE_CYCLES : REPEAT_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_plus,
  input  logic btn_clear,
  output logic plus,
  output logic clear,
  output logic plus_level,
  output logic clear_level
);
  localparam logic [1:0] IDLE = 2'b00, WAIT_HIGH = 2'b01, HIGH = 2'b10, WAIT_LOW = 2'b11;
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] btn, raw, lvl;
  logic rpt;
  assign btn = {btn_clear, btn_plus};
  genvar c;
  for (c = 0; c < 2; c++) begin : g_ch
    logic [1:0] sy, st, nst;
    logic [CNT_W-1:0] cnt;
    logic s;
    assign s = sy[1];
    always_comb
      nst = st == IDLE ? (s ? WAIT_HIGH : IDLE)
          : st == WAIT_HIGH ? (!s ? IDLE : cnt == D_LAST ? HIGH : WAIT_HIGH)
          : st == HIGH ? (s ? HIGH : WAIT_LOW)
          : (s ? HIGH : cnt == D_LAST ? IDLE : WAIT_LOW);
    // the counter only runs in the two WAIT states and restarts on any state change
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        sy  <= '0;
        st  <= IDLE;
        cnt <= '0;
      end else begin
        sy  <= {sy[0], btn[c]};
        st  <= nst;
        cnt <= nst != st ? '0 : st[0] ? cnt + 1'b1 : cnt;
      end
    assign raw[c] = st == WAIT_HIGH && s && cnt == D_LAST;
    assign lvl[c] = st[1];
  end
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rc;
  logic hold;
  assign hold = g_ch[0].st == HIGH && g_ch[0].s;
  always_ff @(posedge clk or posedge rst)
    if (rst) rc <= '0;
    else rc <= hold && rc != R_LAST ? rc + 1'b1 : '0;
  assign rpt = hold && rc == R_LAST;
`else
  assign rpt = 1'b0;
`endif
  // clear wins when both channels fire in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      plus  <= 1'b0;
      clear <= 1'b0;
    end else begin
      plus  <= (raw[0] | rpt) & ~raw[1];
      clear <= raw[1];
    end
  assign plus_level  = lvl[0];
  assign clear_level = lvl[1];
endmodule
